// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus arbiter: grants are held for a whole cyc and hand over without an idle gap.
// Optional watchdog (define WB_RR_ARBITER_TIMEOUT_EN) aborts a cycle that waits too long for ack.
//
// state | meaning
// IDLE  | no master owns the bus, grant_o is zero
// OWNED | grant_o/grant_idx_o select the current owner
module wb_rr_arbiter #(
    parameter int MASTERS_NUM    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IDX_WIDTH     = (MASTERS_NUM > 1) ? $clog2(MASTERS_NUM) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [MASTERS_NUM-1:0] cyc_i,
    input  logic                   ack_i,
    output logic [MASTERS_NUM-1:0] grant_o,
    output logic [IDX_WIDTH-1:0]   grant_idx_o,
    output logic                   busy_o,
    output logic [MASTERS_NUM-1:0] err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [MASTERS_NUM-1:0] grant_q;
    logic [MASTERS_NUM-1:0] lock_q;
    logic [MASTERS_NUM-1:0] req;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [IDX_WIDTH-1:0]   last_q;
    logic [IDX_WIDTH-1:0]   win;
    logic                   win_vld;
    logic                   rel;
    logic                   timeout;

    // Masking the current owner lets the same vector serve both IDLE and a watchdog abort.
    assign req = cyc_i & ~lock_q & ~grant_q;
    assign rel = (state_q == OWNED) && (!cyc_i[idx_q] || timeout);

    always_comb begin
        int j;
        j       = 0;
        win     = last_q;
        win_vld = 1'b0;
        for (int i = 1; i <= MASTERS_NUM; i++) begin
            j = (int'(last_q) + i) % MASTERS_NUM;
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win     = IDX_WIDTH'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_WIDTH'(MASTERS_NUM - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        grant_q <= MASTERS_NUM'(1) << win;
                        idx_q   <= win;
                        last_q  <= win;
                        state_q <= OWNED;
                    end
                end
                OWNED: begin
                    if (rel) begin
                        if (win_vld) begin
                            grant_q <= MASTERS_NUM'(1) << win;
                            idx_q   <= win;
                            last_q  <= win;
                        end else begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = (state_q == OWNED);

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 256) ? 16 : 8;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0]       tmr_q;
    logic [MASTERS_NUM-1:0] err_q;
    logic [MASTERS_NUM-1:0] err_d;

    // Down-counter reloads on every grant, ack or idle; terminal count with no ack aborts the owner.
    assign timeout = (state_q == OWNED) && (tmr_q == '0) && !ack_i;
    assign err_d   = timeout ? grant_q : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr_q  <= TMR_LOAD;
            lock_q <= '0;
            err_q  <= '0;
        end else begin
            if ((state_q != OWNED) || rel || ack_i) begin
                tmr_q <= TMR_LOAD;
            end else begin
                tmr_q <= tmr_q - TMR_W'(1);
            end
            lock_q <= (lock_q & cyc_i) | err_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_cfg;

    assign unused_cfg = ack_i ^ (TIMEOUT_CYCLES < 1);
    assign timeout    = 1'b0;
    assign lock_q     = '0;
    assign err_o      = '0;
`endif

endmodule
